// File: rtl/wr_req_xbar_nxm_if.sv
// Signal bundle for the N-input to M-bank write-request crossbar.
// The slave modport is the crossbar side; master is the surrounding environment.
interface wr_req_xbar_nxm_if #(
  parameter int W_REQ_NUM = 8,
  parameter int BANK_NUM  = 4,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 1024,
  parameter int TXNID_W   = 8,
  parameter int SB_W      = 4,
  parameter int DB_IDX_W  = 4
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SRC_W  = $clog2(W_REQ_NUM);

  // West command ports
  logic [W_REQ_NUM-1:0]               wr_cmd_vld;
  logic [W_REQ_NUM-1:0]               wr_cmd_rdy;
  logic [W_REQ_NUM-1:0][ADDR_W-1:0]   wr_addr;
  logic [W_REQ_NUM-1:0][DATA_W-1:0]   wr_data;
  logic [W_REQ_NUM-1:0][STRB_W-1:0]   wr_strb;
  logic [W_REQ_NUM-1:0][TXNID_W-1:0]  wr_cmd_txnid;
  logic [W_REQ_NUM-1:0][SB_W-1:0]     wr_sideband;

  // Per-bank write-data-buffer allocation
  logic [BANK_NUM-1:0]                alloc_vld;
  logic [BANK_NUM-1:0][DB_IDX_W-1:0]  alloc_idx;
  logic [BANK_NUM-1:0]                alloc_rdy;

  // Per-bank registered outputs
  logic [BANK_NUM-1:0]                sel_wr_vld;
  logic [BANK_NUM-1:0][ADDR_W-1:0]    sel_wr_addr;
  logic [BANK_NUM-1:0][DATA_W-1:0]    sel_wr_data;
  logic [BANK_NUM-1:0][STRB_W-1:0]    sel_wr_strb;
  logic [BANK_NUM-1:0][TXNID_W-1:0]   sel_wr_txnid;
  logic [BANK_NUM-1:0][SB_W-1:0]      sel_wr_sideband;
  logic [BANK_NUM-1:0][DB_IDX_W-1:0]  sel_wr_db_idx;
  logic [BANK_NUM-1:0][SRC_W-1:0]     sel_wr_src;
  logic [BANK_NUM-1:0]                sel_wr_rdy;

  modport slave (
    input  wr_cmd_vld, wr_addr, wr_data, wr_strb, wr_cmd_txnid, wr_sideband,
    input  alloc_vld, alloc_idx, sel_wr_rdy,
    output wr_cmd_rdy, alloc_rdy,
    output sel_wr_vld, sel_wr_addr, sel_wr_data, sel_wr_strb, sel_wr_txnid,
    output sel_wr_sideband, sel_wr_db_idx, sel_wr_src
  );

  modport master (
    output wr_cmd_vld, wr_addr, wr_data, wr_strb, wr_cmd_txnid, wr_sideband,
    output alloc_vld, alloc_idx, sel_wr_rdy,
    input  wr_cmd_rdy, alloc_rdy,
    input  sel_wr_vld, sel_wr_addr, sel_wr_data, sel_wr_strb, sel_wr_txnid,
    input  sel_wr_sideband, sel_wr_db_idx, sel_wr_src
  );
endinterface

// File: rtl/wr_req_xbar_nxm.sv
// N-input to M-bank write crossbar: per-bank round-robin, WDB entry binding, one register slot per bank.
// Optional macro WR_XBAR_ADDR_HASH_EN folds addr[12+:SEL_W] into the bank select.
module wr_req_xbar_nxm #(
  parameter int W_REQ_NUM = 8,
  parameter int BANK_NUM  = 4,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 1024,
  parameter int TXNID_W   = 8,
  parameter int SB_W      = 4,
  parameter int DB_IDX_W  = 4,
  parameter int SEL_LSB   = ADDR_W - $clog2(BANK_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  wr_req_xbar_nxm_if.slave  bus
);
  localparam int SEL_W  = $clog2(BANK_NUM);
  localparam int SRC_W  = $clog2(W_REQ_NUM);
  localparam int STRB_W = DATA_W / 8;

  // Handshake: a transfer happens on any cycle where vld and rdy are both high.
  // Producers hold vld and payload until accepted; wr_cmd_rdy/alloc_rdy are
  // combinational and never depend on a rdy seen by the same producer.

  logic [W_REQ_NUM-1:0][SEL_W-1:0] bank_of;
  logic [BANK_NUM-1:0]             slot_free;
  logic [BANK_NUM-1:0]             gnt_vld;
  logic [BANK_NUM-1:0][SRC_W-1:0]  gnt_idx;
  logic [BANK_NUM-1:0][SRC_W-1:0]  rr;
  logic [BANK_NUM-1:0][SRC_W-1:0]  rr_nxt;
  logic [SRC_W:0]                  sum;
  logic [SRC_W-1:0]                idx;

  logic [BANK_NUM-1:0]               vld_q;
  logic [BANK_NUM-1:0][ADDR_W-1:0]   addr_q;
  logic [BANK_NUM-1:0][DATA_W-1:0]   data_q;
  logic [BANK_NUM-1:0][STRB_W-1:0]   strb_q;
  logic [BANK_NUM-1:0][TXNID_W-1:0]  txnid_q;
  logic [BANK_NUM-1:0][SB_W-1:0]     sb_q;
  logic [BANK_NUM-1:0][DB_IDX_W-1:0] db_idx_q;
  logic [BANK_NUM-1:0][SRC_W-1:0]    src_q;

  always_comb begin
    bank_of = '0;
    for (int i = 0; i < W_REQ_NUM; i++) begin
`ifdef WR_XBAR_ADDR_HASH_EN
      bank_of[i] = bus.wr_addr[i][SEL_LSB+:SEL_W] ^ bus.wr_addr[i][12+:SEL_W];
`else
      bank_of[i] = bus.wr_addr[i][SEL_LSB+:SEL_W];
`endif
    end
  end

  // Per-bank search from rr[b] upward, wrapping; first eligible requester wins.
  always_comb begin
    slot_free = '0;
    gnt_vld   = '0;
    gnt_idx   = '0;
    rr_nxt    = rr;
    sum       = '0;
    idx       = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      slot_free[b] = !vld_q[b] || bus.sel_wr_rdy[b];
      for (int k = 0; k < W_REQ_NUM; k++) begin
        sum = {1'b0, rr[b]} + (SRC_W+1)'(k);
        if (sum >= (SRC_W+1)'(W_REQ_NUM)) sum = sum - (SRC_W+1)'(W_REQ_NUM);
        idx = sum[SRC_W-1:0];
        if (!rst && !gnt_vld[b] && slot_free[b] && bus.alloc_vld[b] &&
            bus.wr_cmd_vld[idx] && bank_of[idx] == SEL_W'(b)) begin
          gnt_vld[b] = 1'b1;
          gnt_idx[b] = idx;
        end
      end
      if (gnt_vld[b]) begin
        rr_nxt[b] = (gnt_idx[b] == SRC_W'(W_REQ_NUM - 1)) ? '0 : gnt_idx[b] + 1'b1;
      end
    end
  end

  always_comb begin
    bus.wr_cmd_rdy = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int i = 0; i < W_REQ_NUM; i++) begin
        if (gnt_vld[b] && gnt_idx[b] == SRC_W'(i)) bus.wr_cmd_rdy[i] = 1'b1;
      end
    end
  end

  assign bus.alloc_rdy = gnt_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      txnid_q  <= '0;
      sb_q     <= '0;
      db_idx_q <= '0;
      src_q    <= '0;
      rr       <= '0;
    end else begin
      rr <= rr_nxt;
      for (int b = 0; b < BANK_NUM; b++) begin
        if (gnt_vld[b]) begin
          vld_q[b]    <= 1'b1;
          addr_q[b]   <= bus.wr_addr[gnt_idx[b]];
          data_q[b]   <= bus.wr_data[gnt_idx[b]];
          strb_q[b]   <= bus.wr_strb[gnt_idx[b]];
          txnid_q[b]  <= bus.wr_cmd_txnid[gnt_idx[b]];
          sb_q[b]     <= bus.wr_sideband[gnt_idx[b]];
          db_idx_q[b] <= bus.alloc_idx[b];
          src_q[b]    <= gnt_idx[b];
        end else if (bus.sel_wr_rdy[b]) begin
          vld_q[b] <= 1'b0;
        end
      end
    end
  end

  assign bus.sel_wr_vld      = vld_q;
  assign bus.sel_wr_addr     = addr_q;
  assign bus.sel_wr_data     = data_q;
  assign bus.sel_wr_strb     = strb_q;
  assign bus.sel_wr_txnid    = txnid_q;
  assign bus.sel_wr_sideband = sb_q;
  assign bus.sel_wr_db_idx   = db_idx_q;
  assign bus.sel_wr_src      = src_q;
endmodule

// File: tb/tb_wr_req_xbar_nxm.sv
// Directed bench for wr_req_xbar_nxm: single write, contention, allocation stall,
// backpressure isolation, asynchronous reset and address-hash routing.
module tb_wr_req_xbar_nxm;
  localparam int W_REQ_NUM = 8;
  localparam int BANK_NUM  = 4;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 1024;
  localparam int TXNID_W   = 8;
  localparam int SB_W      = 4;
  localparam int DB_IDX_W  = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_q[$];

  wr_req_xbar_nxm_if #(
    .W_REQ_NUM(W_REQ_NUM), .BANK_NUM(BANK_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TXNID_W(TXNID_W), .SB_W(SB_W), .DB_IDX_W(DB_IDX_W)
  ) bus ();

  wr_req_xbar_nxm #(
    .W_REQ_NUM(W_REQ_NUM), .BANK_NUM(BANK_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TXNID_W(TXNID_W), .SB_W(SB_W), .DB_IDX_W(DB_IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int i, input logic [7:0] t);
    logic [63:0] w;
    w = {32'hDA7A_0000, 8'(i), t, 16'h5A5A};
    return {16{w}};
  endfunction

  function automatic logic [DATA_W/8-1:0] mk_strb(input int i, input logic [7:0] t);
    logic [7:0] s;
    s = t ^ 8'(i * 17);
    return {16{s}};
  endfunction

  // Drivers
  task automatic set_cmd(input int i, input logic [63:0] addr, input logic [7:0] t);
    bus.wr_cmd_vld[i]   = 1'b1;
    bus.wr_addr[i]      = addr;
    bus.wr_data[i]      = mk_data(i, t);
    bus.wr_strb[i]      = mk_strb(i, t);
    bus.wr_cmd_txnid[i] = t;
    bus.wr_sideband[i]  = SB_W'(i);
  endtask

  task automatic idle();
    bus.wr_cmd_vld = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.wr_cmd_vld   = '0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.wr_strb      = '0;
    bus.wr_cmd_txnid = '0;
    bus.wr_sideband  = '0;
    bus.alloc_vld    = '1;
    bus.alloc_idx    = '0;
    bus.sel_wr_rdy   = '1;

    // Reset: a live request with allocation must not be accepted
    set_cmd(0, 64'h0, 8'h01);
    #2;
    check("rst_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h0);
    check("rst_alloc_rdy", 64'(bus.alloc_rdy), 64'h0);
    check("rst_sel_vld", 64'(bus.sel_wr_vld), 64'h0);
    @(posedge clk);
    step();
    check("rst_sel_vld_hold", 64'(bus.sel_wr_vld), 64'h0);
    idle();
    rst = 1'b0;
    step();

    // Single write: input 3 -> bank 2 (bank 3 when hashed), entry 5
    for (int b = 0; b < BANK_NUM; b++) bus.alloc_idx[b] = 4'd5;
    set_cmd(3, 64'h8000_0000_0000_1000, 8'h33);
    #1;
    check("single_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h08);
`ifdef WR_XBAR_ADDR_HASH_EN
    check("single_alloc_rdy", 64'(bus.alloc_rdy), 64'h8);
    step();
    idle();
    check("single_sel_vld", 64'(bus.sel_wr_vld), 64'h8);
    check("single_db_idx", 64'(bus.sel_wr_db_idx[3]), 64'd5);
    check("single_src", 64'(bus.sel_wr_src[3]), 64'd3);
    check("single_data", 64'(bus.sel_wr_data[3] == mk_data(3, 8'h33)), 64'd1);
    check("single_strb", 64'(bus.sel_wr_strb[3] == mk_strb(3, 8'h33)), 64'd1);
`else
    check("single_alloc_rdy", 64'(bus.alloc_rdy), 64'h4);
    step();
    idle();
    check("single_sel_vld", 64'(bus.sel_wr_vld), 64'h4);
    check("single_db_idx", 64'(bus.sel_wr_db_idx[2]), 64'd5);
    check("single_src", 64'(bus.sel_wr_src[2]), 64'd3);
    check("single_data", 64'(bus.sel_wr_data[2] == mk_data(3, 8'h33)), 64'd1);
    check("single_strb", 64'(bus.sel_wr_strb[2] == mk_strb(3, 8'h33)), 64'd1);
    check("single_addr", bus.sel_wr_addr[2], 64'h8000_0000_0000_1000);
    check("single_txnid", 64'(bus.sel_wr_txnid[2]), 64'h33);
    check("single_sb", 64'(bus.sel_wr_sideband[2]), 64'd3);
`endif
    step();
    check("single_drain", 64'(bus.sel_wr_vld), 64'h0);

    // Contention: inputs 0,1,5 on bank 0, no bubbles
    set_cmd(0, 64'h0000_0000_0000_0040, 8'h10);
    set_cmd(1, 64'h0000_0000_0000_0080, 8'h11);
    set_cmd(5, 64'h0000_0000_0000_00C0, 8'h15);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd5);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd5);
    while (exp_q.size() > 0) begin
      e = int'(exp_q.pop_front());
      #1;
      check("cont_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'(1) << e);
      check("cont_alloc_rdy", 64'(bus.alloc_rdy), 64'h1);
      step();
      check("cont_src", 64'(bus.sel_wr_src[0]), 64'(e));
      check("cont_sel_vld", 64'(bus.sel_wr_vld), 64'h1);
    end
    idle();
    step();
    check("cont_drain", 64'(bus.sel_wr_vld), 64'h0);

    // No allocation on bank 1 for four cycles, then allocation rises
    set_cmd(2, 64'h4000_0000_0000_0080, 8'h22);
    bus.alloc_vld = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("noalloc_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h0);
      check("noalloc_alloc_rdy", 64'(bus.alloc_rdy), 64'h0);
      step();
      check("noalloc_sel_vld", 64'(bus.sel_wr_vld), 64'h0);
    end
    bus.alloc_vld = 4'b1111;
    bus.alloc_idx[1] = 4'd9;
    #1;
    check("alloc_rise_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h04);
    check("alloc_rise_alloc_rdy", 64'(bus.alloc_rdy), 64'h2);
    step();
    idle();
    check("alloc_rise_sel_vld", 64'(bus.sel_wr_vld), 64'h2);
    check("alloc_rise_src", 64'(bus.sel_wr_src[1]), 64'd2);
    check("alloc_rise_db_idx", 64'(bus.sel_wr_db_idx[1]), 64'd9);
    step();

    // Backpressure on bank 0 while bank 3 streams
    set_cmd(0, 64'h0000_0000_0000_0100, 8'h40);
    step();
    check("bp_load", 64'(bus.sel_wr_vld), 64'h1);
    bus.sel_wr_rdy = 4'b1110;
    set_cmd(0, 64'h0000_0000_0000_0100, 8'h41);
    for (int k = 0; k < 3; k++) begin
      set_cmd(4, 64'hC000_0000_0000_0200, 8'(8'h50 + k));
      #1;
      check("bp_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h10);
      check("bp_alloc_rdy", 64'(bus.alloc_rdy), 64'h8);
      step();
      check("bp_sel_vld", 64'(bus.sel_wr_vld), 64'h9);
      check("bp_hold_txnid", 64'(bus.sel_wr_txnid[0]), 64'h40);
      check("bp_hold_data", 64'(bus.sel_wr_data[0] == mk_data(0, 8'h40)), 64'd1);
      check("bp_b3_txnid", 64'(bus.sel_wr_txnid[3]), 64'(8'h50 + k));
    end
    bus.sel_wr_rdy = 4'b1111;
    #1;
    check("bp_release_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h11);
    step();
    idle();
    check("bp_release_txnid", 64'(bus.sel_wr_txnid[0]), 64'h41);
    step();
    check("bp_drain", 64'(bus.sel_wr_vld), 64'h0);

    // Asynchronous reset with banks 0,1,3 holding
    set_cmd(0, 64'h0000_0000_0000_0000, 8'h60);
    set_cmd(1, 64'h4000_0000_0000_0000, 8'h61);
    set_cmd(4, 64'hC000_0000_0000_0000, 8'h62);
    #1;
    check("arst_load_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h13);
    step();
    idle();
    bus.sel_wr_rdy = 4'b0000;
    check("arst_pre_sel_vld", 64'(bus.sel_wr_vld), 64'hB);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel_vld", 64'(bus.sel_wr_vld), 64'h0);
    check("arst_txnid", 64'(bus.sel_wr_txnid[3]), 64'h0);
    check("arst_src", 64'(bus.sel_wr_src[3]), 64'h0);
    step();
    rst = 1'b0;
    bus.sel_wr_rdy = 4'b1111;
    set_cmd(2, 64'h0000_0000_0000_0000, 8'h72);
    set_cmd(5, 64'h0000_0000_0000_0000, 8'h75);
    set_cmd(6, 64'h0000_0000_0000_0000, 8'h76);
    #1;
    check("arst_first_grant", 64'(bus.wr_cmd_rdy), 64'h04);
    step();
    check("arst_first_src", 64'(bus.sel_wr_src[0]), 64'd2);
    #1;
    check("arst_second_grant", 64'(bus.wr_cmd_rdy), 64'h20);
    idle();
    step();
    step();

    // Hash routing of addr 0x1000
    set_cmd(7, 64'h0000_0000_0000_1000, 8'h77);
    #1;
    check("hash_cmd_rdy", 64'(bus.wr_cmd_rdy), 64'h80);
`ifdef WR_XBAR_ADDR_HASH_EN
    check("hash_alloc_rdy", 64'(bus.alloc_rdy), 64'h2);
    step();
    check("hash_sel_vld", 64'(bus.sel_wr_vld), 64'h2);
    check("hash_src", 64'(bus.sel_wr_src[1]), 64'd7);
`else
    check("hash_alloc_rdy", 64'(bus.alloc_rdy), 64'h1);
    step();
    check("hash_sel_vld", 64'(bus.sel_wr_vld), 64'h1);
    check("hash_src", 64'(bus.sel_wr_src[0]), 64'd7);
`endif
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wr_req_xbar_nxm.md
Name: wr_req_xbar_nxm

Overview:
- Parametrised N-input to M-bank write-request crossbar; next generation of the fixed 8-to-4 write xbar.
- Routes each write command plus data to a bank chosen from address bits, using per-bank round-robin arbitration.
- A command is accepted only when the target bank has a write-data-buffer (WDB) entry allocated; the entry index is attached to the payload.
- Each bank output is registered (one entry per bank) and sits between the west write ports and the per-bank WDB/tag pipelines.

Parameters:
- W_REQ_NUM, 8, number of input write ports (>=2).
- BANK_NUM, 4, number of output banks (power of 2, >=2); SEL_W = $clog2(BANK_NUM).
- ADDR_W, 64, address width.
- DATA_W, 1024, write data width; strobe width is DATA_W/8.
- TXNID_W, TXNID_WIDTH, transaction id width.
- SB_W, SIDEBAND_WIDTH, sideband width.
- DB_IDX_W, DB_ENTRY_IDX_WIDTH, WDB entry index width.
- SEL_LSB, ADDR_W-SEL_W, LSB of the bank-select field addr[SEL_LSB+:SEL_W].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- wr_cmd_vld  in  W_REQ_NUM  per-input command valid.
- wr_cmd_rdy  out  W_REQ_NUM  per-input accept.
- wr_addr  in  ADDR_W x W_REQ_NUM  address.
- wr_data  in  DATA_W x W_REQ_NUM  data.
- wr_strb  in  DATA_W/8 x W_REQ_NUM  byte strobes.
- wr_cmd_txnid  in  TXNID_W x W_REQ_NUM  transaction id.
- wr_sideband  in  SB_W x W_REQ_NUM  sideband.
- alloc_vld  in  BANK_NUM  WDB entry available per bank.
- alloc_idx  in  DB_IDX_W x BANK_NUM  offered WDB entry per bank.
- alloc_rdy  out  BANK_NUM  WDB entry consumed this cycle.
- sel_wr_vld  out  BANK_NUM  bank output valid.
- sel_wr_addr, sel_wr_data, sel_wr_strb, sel_wr_txnid, sel_wr_sideband  out  per-field width x BANK_NUM  routed payload.
- sel_wr_db_idx  out  DB_IDX_W x BANK_NUM  WDB entry bound to this command.
- sel_wr_src  out  $clog2(W_REQ_NUM) x BANK_NUM  originating input index.
- sel_wr_rdy  in  BANK_NUM  bank consumer ready.

Behaviour:
- Bank select: bank(i) = addr_i[SEL_LSB+:SEL_W]; input i requests bank b when wr_cmd_vld[i] && bank(i)==b.
- Output slot b is "free" when !sel_wr_vld[b] || sel_wr_rdy[b], so a slot can drain and reload in the same cycle (full throughput).
- Grant condition for bank b: at least one request, alloc_vld[b]=1, and slot free. The winner is chosen round-robin.
- Round-robin: per-bank pointer rr[b]. Search starts at rr[b] and wraps modulo W_REQ_NUM. On grant to input g, rr[b] <= (g+1) mod W_REQ_NUM. With no grant the pointer holds.
- wr_cmd_rdy[i] is combinational: asserted only for the granted input of its bank, and never when wr_cmd_vld[i]=0.
- alloc_rdy[b] = grant on b (combinational). The alloc_idx[b] value is captured with the payload.
- Grant to b with slot free: next-cycle sel_wr_vld[b]=1, and the payload, db_idx and src registers load.
- Slot drained with no grant: sel_wr_vld[b]<=0.
- Latency is 1 cycle from input accept to bank output valid.
- sel_wr_vld[b]=1 && !sel_wr_rdy[b]: all sel_wr_* for that bank hold stable, no grant is issued on b, and the inputs targeting b see rdy=0.
- Banks are independent: a stall on one bank never blocks grants on the others.
- Input vld may drop without acceptance; the pointer is unaffected.
- Opcode is implicitly write; there is no opcode port.
- Reset (asynchronous, rst=1): sel_wr_vld=0, rr[*]=0, all payload registers 0. wr_cmd_rdy and alloc_rdy are therefore 0 while in reset.
- Reset asserted mid-transfer drops any held slot content; there is no partial replay.

Optional Feature:
- Macro: WR_XBAR_ADDR_HASH_EN.
- Defined: bank(i) = addr_i[SEL_LSB+:SEL_W] XOR addr_i[12+:SEL_W]. This spreads strided traffic across banks; all other behaviour is unchanged.
- Undefined: bank(i) = addr_i[SEL_LSB+:SEL_W] only.

Test Plan:
- Single write, defaults: input 3 sends addr=0x8000_0000_0000_1000 (bank 2), alloc_vld[2]=1, alloc_idx[2]=5. Expect wr_cmd_rdy[3] and alloc_rdy[2] in cycle T; sel_wr_vld[2]=1 at T+1 with db_idx=5, src=3 and matching data/strb.
- Contention: inputs 0, 1 and 5 all target bank 0 continuously, alloc and sel_wr_rdy held 1. Expect grants 0, 1, 5, 0, 1, 5 on consecutive cycles, one accept per cycle, with no bubbles.
- No allocation: bank 1 request with alloc_vld[1]=0 for 4 cycles. Expect wr_cmd_rdy=0, alloc_rdy[1]=0 and sel_wr_vld[1]=0 throughout; accept occurs in the cycle alloc_vld[1] rises.
- Backpressure isolation: sel_wr_rdy[0]=0 while bank 0 holds valid. Bank 0 payload stays stable and bank 0 requesters are stalled, while a concurrent bank 3 stream still accepts one per cycle.
- Async reset: assert rst mid-stream, between clock edges, with sel_wr_vld=4'b1011. All sel_wr_vld drop immediately; after release, the first contention grant goes to the lowest requesting index.
- With WR_XBAR_ADDR_HASH_EN defined: addr 0x0000_0000_0000_1000 routes to bank 1 (bank 0 without the macro).
